// File: rtl/dec_pkg.sv
// Shared types and sizes for the 5->32 strobe decoder.
package dec_pkg;
  localparam int CODE_W  = 5;
  localparam int N_LINES = 32;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code_n;
    logic              gs_n;
  } word_t;
endpackage

// File: rtl/decoder5_32_core.sv
// Combinational complemented-code to active-low one-hot decoder, built as two
// 16-line halves with the upper index bit acting as the half enable.
module decoder5_32_core
  import dec_pkg::*;
(
  input  logic [CODE_W-1:0]  code_n,
  output logic [N_LINES-1:0] y_n
);
  logic [CODE_W-1:0] idx;
  logic [1:0][15:0]  half_n;

  assign idx = ~code_n;

  for (genvar h = 0; h < 2; h++) begin : g_half
    always_comb begin
      half_n[h] = '1;
      if (idx[4] == 1'(h)) half_n[h][idx[3:0]] = 1'b0;
    end
  end

  assign y_n = half_n;
endmodule

// File: rtl/strobe_decoder5_32.sv
// Timed one-hot strobe generator: accepts complemented codes over valid/ready,
// buffers one word while a strobe/gap is in flight, and drives registered y_n.
module strobe_decoder5_32
  import dec_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  code_n,
  input  logic               gs_n,
  output logic [N_LINES-1:0] y_n,
  output logic               busy,
  output logic               done,
  output logic               empty_p
);
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_LEN - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               hold_valid, hold_valid_nx;
  word_t              hold, hold_nx;
  word_t              in_word, launch;
  logic               launch_en, xfer;
  logic [N_LINES-1:0] dec_n, y_nx;
  logic               done_nx, empty_nx;

  assign in_ready = ~en_n & ~hold_valid;
  assign xfer     = in_valid & in_ready;
  assign in_word  = '{code_n: code_n, gs_n: gs_n};
  assign busy     = (state != IDLE) | hold_valid;

  decoder5_32_core u_core (
    .code_n (launch.code_n),
    .y_n    (dec_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_valid <= 1'b0;
      hold       <= '0;
      y_n        <= '1;
      done       <= 1'b0;
      empty_p    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      hold_valid <= hold_valid_nx;
      hold       <= hold_nx;
      y_n        <= y_nx;
      done       <= done_nx;
      empty_p    <= empty_nx;
    end
  end

  // cnt holds the cycles remaining in the current phase after this one
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    hold_valid_nx = hold_valid;
    hold_nx       = hold;
    launch        = in_word;
    launch_en     = 1'b0;
    if (en_n) begin
      state_nx      = IDLE;
      cnt_nx        = '0;
      hold_valid_nx = 1'b0;
    end else begin
      unique case (state)
        IDLE: launch_en = xfer;
        PULSE: begin
          if (cnt != '0) cnt_nx = cnt - 1'b1;
          else begin
            state_nx = GAP;
            cnt_nx   = G_LOAD;
          end
          if (xfer) begin
            hold_valid_nx = 1'b1;
            hold_nx       = in_word;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
            if (xfer) begin
              hold_valid_nx = 1'b1;
              hold_nx       = in_word;
            end
          end else if (hold_valid) begin
            launch        = hold;
            launch_en     = 1'b1;
            hold_valid_nx = 1'b0;
          end else if (xfer) begin
            launch_en = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
      // An empty word takes no strobe time, so it lands straight in IDLE
      if (launch_en) begin
        state_nx = launch.gs_n ? IDLE : PULSE;
        cnt_nx   = launch.gs_n ? '0 : P_LOAD;
      end
    end
  end

  always_comb begin
    y_nx     = '1;
    done_nx  = 1'b0;
    empty_nx = 1'b0;
    if (!en_n) begin
      if (launch_en) begin
        if (launch.gs_n) empty_nx = 1'b1;
        else begin
          y_nx    = dec_n;
          done_nx = (P_LOAD == '0);
        end
      end else if (state == PULSE && cnt != '0) begin
        y_nx    = y_n;
        done_nx = (cnt == CNT_W'(1));
      end
    end
  end
endmodule

// File: tb/tb_strobe_decoder5_32.sv
// Bench for strobe_decoder5_32: per-cycle schedule model plus directed literal checks.
module tb_strobe_decoder5_32;
  localparam int P  = 4;
  localparam int G  = 1;
  localparam int NC = 4096;

  logic        clk = 1'b0, rst_n = 1'b0, en_n = 1'b0, in_valid = 1'b0, gs_n = 1'b1;
  logic [4:0]  code_n = 5'd0;
  logic        in_ready, busy, done, empty_p;
  logic [31:0] y_n;

  always #5 clk = ~clk;

  strobe_decoder5_32 #(.PULSE_LEN(P), .GAP_LEN(G)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_n(code_n), .gs_n(gs_n), .y_n(y_n), .busy(busy), .done(done), .empty_p(empty_p)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  // Expected outputs indexed by absolute cycle number
  logic [31:0] e_y[NC];
  bit          e_done[NC], e_empty[NC], e_busy[NC];
  int          free_c = 1, last_start = -1;
  bit          xfer_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clr(input int from);
    for (int i = from; i < from + 64 && i < NC; i++) begin
      e_y[i] = '1; e_done[i] = 0; e_empty[i] = 0; e_busy[i] = 0;
    end
  endtask

  // Model: each accepted word owns a slot (P low + G high cycles, or one empty cycle)
  // starting at max(cycle after acceptance, end of previous slot).
  initial begin
    for (int i = 0; i < NC; i++) begin
      e_y[i] = '1; e_done[i] = 0; e_empty[i] = 0; e_busy[i] = 0;
    end
    forever begin
      int c, s;
      logic [4:0] idx;
      @(posedge clk);
      c = cyc;
      xfer_m = 1'b0;
      if (!rst_n || en_n) begin
        clr(c + 1);
        free_c = c + 1;
        last_start = -1;
      end else if (in_valid && !(last_start > c)) begin
        xfer_m = 1'b1;
        s = (free_c > c + 1) ? free_c : c + 1;
        for (int i = c + 1; i < s; i++) e_busy[i] = 1;
        if (!gs_n) begin
          idx = ~code_n;
          for (int i = 0; i < P; i++) e_y[s+i] = ~(32'd1 << idx);
          e_done[s+P-1] = 1;
          for (int i = 0; i < P + G; i++) e_busy[s+i] = 1;
          free_c = s + P + G;
        end else begin
          e_empty[s] = 1;
          free_c = s + 1;
        end
        last_start = s;
      end
      cyc = c + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_y_n", y_n, 32'hFFFF_FFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_empty_p", 32'(empty_p), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'(!en_n));
      end else begin
        chk("y_n", y_n, e_y[cyc]);
        chk("done", 32'(done), 32'(e_done[cyc]));
        chk("empty_p", 32'(empty_p), 32'(e_empty[cyc]));
        chk("busy", 32'(busy), 32'(e_busy[cyc]));
        chk("in_ready", 32'(in_ready), 32'(!en_n && !(last_start > cyc)));
        chk("onehot", 32'($countones(~y_n) <= 1), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] words [3];
    int k, cnt;
    // Reset with enable asserted
    tick(); tick();
    at_neg();
    chk("t1_y_n", y_n, 32'hFFFF_FFFF);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single strobe on line 31
    tick();
    code_n = 5'b00000; gs_n = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      at_neg();
      if (j <= 4) begin
        chk("t2_y_low", y_n, 32'h7FFF_FFFF);
        chk("t2_done", 32'(done), 32'(j == 4));
      end else if (j == 5) chk("t2_gap", y_n, 32'hFFFF_FFFF);
      else chk("t2_idle_busy", 32'(busy), 32'd0);
      if (j < 6) tick();
    end

    // Back-to-back codes with valid held high
    words[0] = 5'b11111; words[1] = 5'b11110; words[2] = 5'b11101;
    tick();
    k = 0;
    in_valid = 1'b1; gs_n = 1'b0; code_n = words[0];
    for (int t = 0; t < 40 && k < 3; t++) begin
      tick();
      if (xfer_m) k++;
      if (k < 3) code_n = words[k];
    end
    in_valid = 1'b0;
    chk("t3_accepted", 32'(k), 32'd3);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      tick(); at_neg();
      if (y_n == 32'hFFFF_FFFB) cnt++;
    end
    chk("t3_fffb_cycles", 32'(cnt), 32'd4);

    // Empty word in IDLE
    tick();
    in_valid = 1'b1; gs_n = 1'b1; code_n = 5'b01010;
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t4_empty_p", 32'(empty_p), 32'd1);
    chk("t4_y_n", y_n, 32'hFFFF_FFFF);
    chk("t4_done", 32'(done), 32'd0);
    tick(); at_neg();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_empty_gone", 32'(empty_p), 32'd0);

    // Abort on second pulse cycle with a word in hold
    tick();
    in_valid = 1'b1; gs_n = 1'b0; code_n = 5'b10101;
    tick();
    code_n = 5'b00011;
    tick();
    in_valid = 1'b0; en_n = 1'b1;
    at_neg();
    chk("t5_ready_en", 32'(in_ready), 32'd0);
    tick(); at_neg();
    chk("t5_y_n", y_n, 32'hFFFF_FFFF);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    tick();
    en_n = 1'b0;
    at_neg();
    chk("t5_ready_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b1; code_n = 5'b11100;
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t5_fresh", y_n, 32'hFFFF_FFF7);
    repeat (8) tick();

    // Async reset in the middle of a pulse
    in_valid = 1'b1; gs_n = 1'b0; code_n = 5'b01111;
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t6_pre", y_n, 32'hFFFE_FFFF);
    #1 rst_n = 1'b0;
    #1 chk("t6_async_y", y_n, 32'hFFFF_FFFF);
    chk("t6_async_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; code_n = 5'b11000;
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t6_after", y_n, 32'hFFFF_FF7F);
    repeat (8) tick();

    // Random sweep against the model
    for (int t = 0; t < 1500; t++) begin
      tick();
      en_n     = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      code_n   = 5'($urandom);
      gs_n     = ($urandom_range(0, 7) == 0);
    end
    tick();
    en_n = 1'b0; in_valid = 1'b0;
    repeat (12) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
